scan_test_ctrl: RTL and testbench

SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

---
 rtl/scan_test_ctrl.sv | 126 ++++++++++++
 tb/tb_scan_test_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/scan_test_ctrl.sv
// Scan test controller: shifts a pattern into a scan chain, runs functional capture cycles,
// unloads the captured response and compares it against a golden value.
module scan_test_ctrl #(
   parameter int unsigned CHAIN_LEN = 4,
   parameter int unsigned CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern,
   input  logic [CHAIN_LEN-1:0] expected,
   input  logic [3:0]           n_capture,
   input  logic                 scan_out,
   output logic                 NbarT,
   output logic                 Si,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CHAIN_LEN-1:0] response
);

   typedef enum logic [2:0] {StIdle, StShiftIn, StCapture, StShiftOut, StDone} state_e;

   localparam logic [CNT_W-1:0] LastShift = CNT_W'(CHAIN_LEN - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
   logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
   logic [CHAIN_LEN-1:0] expected_q, expected_d;
   logic [3:0]           ncap_q, ncap_d, ncap_eff;
   logic [CHAIN_LEN-1:0] response_q, response_d;
   logic                 pass_q, pass_d;
   logic                 shift_last, cap_last;

   // Counter saturates rather than wrapping; every state exit reloads it with zero.
   assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   assign ncap_eff   = (ncap_q == 4'd0) ? 4'd1 : ncap_q;
   assign shift_last = (cnt_q == LastShift);
   assign cap_last   = (32'(cnt_q) == 32'(ncap_eff) - 32'd1);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_inc;
      pattern_d  = pattern_q;
      expected_d = expected_q;
      ncap_d     = ncap_q;
      response_d = response_q;
      pass_d     = pass_q;
      NbarT      = 1'b0;
      Si         = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (start) begin
               pattern_d  = pattern;
               expected_d = expected;
               ncap_d     = n_capture;
               response_d = '0;
               pass_d     = 1'b0;
               state_d    = StShiftIn;
            end
         end
         StShiftIn: begin
            NbarT = 1'b1;
            // MSB first, so the first bit shifted ends up in the flop nearest scan_out.
            for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
               if (cnt_q == CNT_W'(i)) Si = pattern_q[CHAIN_LEN-1-i];
            end
            if (shift_last) begin
               state_d = StCapture;
               cnt_d   = '0;
            end
         end
         StCapture: begin
            if (cap_last) begin
               state_d = StShiftOut;
               cnt_d   = '0;
            end
         end
         StShiftOut: begin
            NbarT      = 1'b1;
            response_d = {response_q[CHAIN_LEN-2:0], scan_out};
            if (shift_last) begin
               state_d = StDone;
               cnt_d   = '0;
               pass_d  = (response_d == expected_q);
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         pattern_q  <= '0;
         expected_q <= '0;
         ncap_q     <= '0;
         response_q <= '0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pattern_q  <= pattern_d;
         expected_q <= expected_d;
         ncap_q     <= ncap_d;
         response_q <= response_d;
         pass_q     <= pass_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign pass     = pass_q;
   assign response = response_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl driving a 4-flop scan chain whose functional capture is either
// identity or inversion, checked cycle by cycle against a timeline built from the test rules.
module tb_scan_test_ctrl;

   localparam int L = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [L-1:0] pattern;
   logic [L-1:0] expected;
   logic [3:0]   n_capture;
   logic         scan_out;
   logic         NbarT;
   logic         Si;
   logic         busy;
   logic         done;
   logic         pass;
   logic [L-1:0] response;

   logic [L-1:0] chain;
   logic         cap_inv;
   int           n_cmp = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   scan_test_ctrl #(
      .CHAIN_LEN(L),
      .CNT_W    (5)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .pattern  (pattern),
      .expected (expected),
      .n_capture(n_capture),
      .scan_out (scan_out),
      .NbarT    (NbarT),
      .Si       (Si),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .response (response)
   );

   // Scan chain: flop 0 takes Si, flop L-1 drives scan_out; functional mode holds or inverts.
   always @(posedge clk) begin
      if (NbarT) chain <= {chain[L-2:0], Si};
      else if (cap_inv) chain <= ~chain;
   end
   assign scan_out = chain[L-1];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic check_quiet(input string tag);
      check_val({tag, " NbarT"}, 32'(NbarT), 0);
      check_val({tag, " Si"}, 32'(Si), 0);
      check_val({tag, " busy"}, 32'(busy), 0);
      check_val({tag, " done"}, 32'(done), 0);
   endtask

   // One full test. abort_at > 0 pulls reset low in that cycle (counted from the start edge).
   task automatic run_test(input logic [L-1:0] pat, input logic [L-1:0] exp_v,
                           input logic [3:0] nc, input logic inv, input logic hold,
                           input int abort_at);
      int           nce;
      int           lat;
      logic [L-1:0] capt;
      logic         exp_pass;
      bit           q_nb[$];
      bit           q_si[$];
      nce      = (nc == 4'd0) ? 1 : int'(nc);
      lat      = 2 * L + nce + 1;
      capt     = (inv && (nce % 2 == 1)) ? ~pat : pat;
      exp_pass = (capt == exp_v);
      for (int k = 0; k < L; k++) begin q_nb.push_back(1'b1); q_si.push_back(pat[L-1-k]); end
      for (int k = 0; k < nce; k++) begin q_nb.push_back(1'b0); q_si.push_back(1'b0); end
      for (int k = 0; k < L; k++) begin q_nb.push_back(1'b1); q_si.push_back(1'b0); end
      q_nb.push_back(1'b0);
      q_si.push_back(1'b0);

      @(negedge clk);
      cap_inv   = inv;
      pattern   = pat;
      expected  = exp_v;
      n_capture = nc;
      start     = 1'b1;
      for (int j = 1; j <= lat + 1; j++) begin
         @(posedge clk);
         #1;
         if (j <= lat) begin
            check_val($sformatf("c%0d NbarT", j), 32'(NbarT), 32'(q_nb[j-1]));
            check_val($sformatf("c%0d Si", j), 32'(Si), 32'(q_si[j-1]));
            check_val($sformatf("c%0d busy", j), 32'(busy), 1);
            check_val($sformatf("c%0d done", j), 32'(done), 32'(j == lat));
            if (j == lat) begin
               check_val("done pass", 32'(pass), 32'(exp_pass));
               check_val("done response", 32'(response), 32'(capt));
            end
         end else begin
            check_quiet("idle after done");
            check_val("held pass", 32'(pass), 32'(exp_pass));
            check_val("held response", 32'(response), 32'(capt));
         end
         if (j == abort_at) begin
            #2 rst = 1'b0;
            #1;
            check_quiet("abort");
            check_val("abort pass", 32'(pass), 0);
            check_val("abort response", 32'(response), 0);
            repeat (3) begin
               @(posedge clk);
               #1;
               check_quiet("in reset");
            end
            @(negedge clk);
            rst   = 1'b1;
            start = 1'b0;
            return;
         end
         if (j <= lat) begin
            @(negedge clk);
            if (j == lat) begin
               start = hold;
            end else begin
               // Input churn while busy must not disturb the running test.
               start     = hold | 1'($urandom_range(0, 1));
               pattern   = L'($urandom);
               expected  = L'($urandom);
               n_capture = 4'($urandom);
            end
         end
      end
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b1;
      pattern   = 4'b1111;
      expected  = 4'b1111;
      n_capture = 4'd2;
      cap_inv   = 1'b0;
      chain     = '0;
      #3;
      check_quiet("reset");
      check_val("reset pass", 32'(pass), 0);
      check_val("reset response", 32'(response), 0);
      @(posedge clk);
      #1;
      check_quiet("reset edge");
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         pattern = L'($urandom);
         @(posedge clk);
         #1;
         check_quiet("post reset idle");
      end

      run_test(4'b1011, 4'b1011, 4'd1, 1'b0, 1'b0, 0);
      run_test(4'b1011, 4'b1010, 4'd1, 1'b0, 1'b0, 0);
      run_test(4'b1011, 4'b1011, 4'd0, 1'b0, 1'b0, 0);
      run_test(4'b1011, 4'b1011, 4'd3, 1'b0, 1'b0, 0);
      run_test(4'b0110, 4'b0110, 4'd1, 1'b0, 1'b0, 0);
      run_test(4'b0110, 4'b1001, 4'd3, 1'b1, 1'b0, 0);
      run_test(4'b1100, 4'b1100, 4'd2, 1'b0, 1'b1, 0);
      run_test(4'b0101, 4'b0101, 4'd1, 1'b1, 1'b1, 0);
      run_test(4'b1110, 4'b1110, 4'd4, 1'b1, 1'b0, 0);
      run_test(4'b1011, 4'b1011, 4'd1, 1'b0, 1'b0, L + 1 + 2);
      run_test(4'b1011, 4'b1011, 4'd1, 1'b0, 1'b0, 0);

      for (int t = 0; t < 20; t++) begin
         logic [L-1:0] p;
         logic [L-1:0] e;
         logic         h;
         p = L'($urandom);
         e = ($urandom_range(0, 1) == 1) ? p : L'($urandom);
         h = 1'($urandom_range(0, 1));
         run_test(p, e, 4'($urandom), 1'($urandom_range(0, 1)), h, 0);
         if (!h) repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
